// File: rtl/i2c_slave_if.sv
// I2C target bus bundle: open-drain line levels/enables plus the byte-level
// rx/tx handshakes toward the local logic.
interface i2c_slave_if;
    logic       scl;       // raw SCL level
    logic       sda_i;     // raw SDA level
    logic       sda_oe;    // 1 = pull SDA low
    logic       scl_oe;    // 1 = pull SCL low (stretch)
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack;
    logic       busy;

    modport slave (
        input  scl, sda_i, tx_data, tx_valid,
        output sda_oe, scl_oe, rx_data, rx_valid, tx_ack, busy
    );

    modport master (
        output scl, sda_i, tx_data, tx_valid,
        input  sda_oe, scl_oe, rx_data, rx_valid, tx_ack, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, write receive with
// unconditional ACK, read transmit with master ACK/NACK handling.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low while tx_data is not yet valid.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         ADDR_BIT   = 7
) (
    input  logic        scl_clk,
    input  logic        reset,
    i2c_slave_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, RX, ACK_RX, TX, ACK_TX, WAIT_STOP
    } state_t;

    // [0],[1] synchronize, [2] is the previous synchronized sample
    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_now, scl_prev, sda_now, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ack_q, tx_ack_d;
    logic       busy_q, busy_d;
    logic       load_req;
`ifdef I2C_SLAVE_STRETCH_EN
    logic       scl_oe_q, scl_oe_d;
    logic       pend_q, pend_d;
`else
    logic       unused_tx_valid;
    assign unused_tx_valid = bus.tx_valid;
`endif

    // Bus line synchronizers; idle bus is high on both lines
    always_ff @(posedge scl_clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], bus.scl};
            sda_sync_q <= {sda_sync_q[1:0], bus.sda_i};
        end
    end

    assign scl_now   = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_now   = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

    // State and datapath registers
    always_ff @(posedge scl_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sr_q       <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_q   <= 1'b0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            busy_q     <= busy_d;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_q   <= scl_oe_d;
            pend_q     <= pend_d;
`endif
        end
    end

    // Next-state logic; bus START/STOP override everything at the end
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;
        busy_d     = busy_q;
        load_req   = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oe_d   = scl_oe_q;
        pend_d     = pend_q;
`endif
        case (state_q)
            ADDR, RX: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    sr_d  = {sr_q[6:0], sda_now};
                    cnt_d = cnt_q + 4'd1;
                end
                if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d = 4'd0;
                    if (state_q == RX) begin
                        rx_data_d  = sr_q;
                        rx_valid_d = 1'b1;
                        sda_oe_d   = 1'b1;
                        state_d    = ACK_RX;
                    end else if (sr_q[7:1] == SLAVE_ADDR) begin
                        rw_d     = sr_q[0];
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ACK_ADDR;
                    end else begin
                        sda_oe_d = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = WAIT_STOP;
                    end
                end
            end
            ACK_ADDR: begin
                if (scl_fall) begin
                    cnt_d = 4'd0;
                    if (!rw_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = RX;
                    end else begin
                        load_req = 1'b1;
                    end
                end
            end
            ACK_RX: begin
                if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = RX;
                end
            end
            TX: begin
`ifdef I2C_SLAVE_STRETCH_EN
                // Release the stretch one cycle after the byte was loaded
                if (scl_oe_q) scl_oe_d = 1'b0;
`endif
                if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = ACK_TX;
                    end else begin
                        sda_oe_d = ~sr_q[6];
                        sr_d     = {sr_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 4'd1;
                    end
                end
            end
            ACK_TX: begin
                if (scl_rise && sda_now) begin
                    busy_d  = 1'b0;
                    state_d = WAIT_STOP;
                end else if (scl_fall) begin
                    load_req = 1'b1;
                end
            end
            WAIT_STOP: sda_oe_d = 1'b0;
            default: ;
        endcase

        // Byte load for transmit: first bit goes out in the same cycle
`ifdef I2C_SLAVE_STRETCH_EN
        if (load_req || pend_q) begin
            if (bus.tx_valid) begin
                sr_d     = bus.tx_data;
                tx_ack_d = 1'b1;
                sda_oe_d = ~bus.tx_data[7];
                cnt_d    = 4'd1;
                pend_d   = 1'b0;
                state_d  = TX;
            end else begin
                scl_oe_d = 1'b1;
                pend_d   = 1'b1;
            end
        end
`else
        if (load_req) begin
            sr_d     = bus.tx_data;
            tx_ack_d = 1'b1;
            sda_oe_d = ~bus.tx_data[7];
            cnt_d    = 4'd1;
            state_d  = TX;
        end
`endif

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = 4'd0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_d = 1'b0;
            pend_d   = 1'b0;
`endif
        end else if (start_det) begin
            state_d  = ADDR;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe_d = 1'b0;
            pend_d   = 1'b0;
`endif
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_ack   = tx_ack_q;
    assign bus.busy     = busy_q;
`ifdef I2C_SLAVE_STRETCH_EN
    assign bus.scl_oe   = scl_oe_q;
`else
    assign bus.scl_oe   = 1'b0;
`endif
endmodule
